// File: rtl/sym_phase_decim.sv
// Symbol-timing decimator: accumulates |I|+|Q| per sampling phase over an
// acquisition window, picks the strongest phase, then emits one I/Q per symbol.
module sym_phase_decim #(
  parameter int OSF      = 20,
  parameter int WI       = 18,
  parameter int ACQ_SYMS = 64,
  parameter int ACC_W    = WI + 1 + $clog2(ACQ_SYMS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [WI-1:0]   i_in,
  input  logic signed [WI-1:0]   q_in,
  input  logic                   iq_val_i,
  input  logic                   reacq_i,
  output logic signed [WI-1:0]   i_sym,
  output logic signed [WI-1:0]   q_sym,
  output logic                   sym_val_o,
  output logic [$clog2(OSF)-1:0] phase_o,
  output logic                   lock_o
);

  localparam int PW = $clog2(OSF);
  localparam int SW = $clog2(ACQ_SYMS);
  localparam logic [PW-1:0] LAST_PH  = PW'(OSF - 1);
  localparam logic [SW-1:0] LAST_SYM = SW'(ACQ_SYMS - 1);

  typedef enum logic [1:0] {
    S_ACQ = 2'd0,
    S_SEL = 2'd1,
    S_TRK = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [PW-1:0]        r_phase;
  logic [PW-1:0]        r_scan;
  logic [PW-1:0]        r_best_idx;
  logic [PW-1:0]        r_phase_o;
  logic [SW-1:0]        r_sym_cnt;
  logic [ACC_W-1:0]     r_bin [OSF];
  logic [ACC_W-1:0]     r_best_val;
  logic signed [WI-1:0] r_i_sym;
  logic signed [WI-1:0] r_q_sym;
  logic                 r_sym_val;

  logic                 w_take;
  logic                 w_last_ph;
  logic                 w_acq_done;
  logic                 w_acc_en;
  logic                 w_scan_last;
  logic                 w_gt;
  logic                 w_hit;
  logic [WI-1:0]        w_abs_i;
  logic [WI-1:0]        w_abs_q;
  logic [WI:0]          w_mag;
  logic [ACC_W-1:0]     w_scan_val;
  logic [PW-1:0]        w_best_idx_new;
  logic [OSF-1:0]       w_bin_en;

  // Negating the most negative code wraps to the same bit pattern, which read
  // as unsigned is exactly 2^(WI-1): the magnitude needs no saturation.
  assign w_abs_i = i_in[WI-1] ? $unsigned(-i_in) : $unsigned(i_in);
  assign w_abs_q = q_in[WI-1] ? $unsigned(-q_in) : $unsigned(q_in);
  assign w_mag   = {1'b0, w_abs_i} + {1'b0, w_abs_q};

  assign w_take      = iq_val_i && !reacq_i;
  assign w_last_ph   = (r_phase == LAST_PH);
  assign w_acc_en    = (r_state == S_ACQ) && w_take;
  assign w_acq_done  = w_acc_en && w_last_ph && (r_sym_cnt == LAST_SYM);
  assign w_scan_last = (r_scan == LAST_PH);
  assign w_scan_val  = r_bin[r_scan];
  assign w_gt        = (w_scan_val > r_best_val);
  assign w_best_idx_new = w_gt ? r_scan : r_best_idx;
  assign w_hit       = (r_state == S_TRK) && w_take && (r_phase == r_phase_o);

  genvar gi;
  generate
    for (gi = 0; gi < OSF; gi++) begin : g_bin_en
      assign w_bin_en[gi] = w_acc_en && (r_phase == PW'(gi));
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_ACQ;
    else      r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (reacq_i) begin
      w_state_next = S_ACQ;
    end else begin
      case (r_state)
        S_ACQ:   if (w_acq_done)  w_state_next = S_SEL;
        S_SEL:   if (w_scan_last) w_state_next = S_TRK;
        S_TRK:   w_state_next = S_TRK;
        default: w_state_next = S_ACQ;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    lock_o = (r_state == S_TRK);
  end

  assign i_sym     = r_i_sym;
  assign q_sym     = r_q_sym;
  assign sym_val_o = r_sym_val;
  assign phase_o   = r_phase_o;

  // Phase counter advances on every valid sample in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase   <= '0;
      r_sym_cnt <= '0;
    end else if (reacq_i) begin
      r_phase   <= '0;
      r_sym_cnt <= '0;
    end else begin
      if (iq_val_i) r_phase <= w_last_ph ? '0 : r_phase + 1'b1;
      if (w_acc_en && w_last_ph) r_sym_cnt <= r_sym_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < OSF; k++) r_bin[k] <= '0;
    end else if (reacq_i) begin
      for (int k = 0; k < OSF; k++) r_bin[k] <= '0;
    end else begin
      for (int k = 0; k < OSF; k++)
        if (w_bin_en[k]) r_bin[k] <= r_bin[k] + ACC_W'(w_mag);
    end
  end

  // Max scan; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan     <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_phase_o  <= '0;
    end else if (reacq_i || r_state != S_SEL) begin
      r_scan     <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
    end else begin
      r_scan <= w_scan_last ? '0 : r_scan + 1'b1;
      if (w_gt) begin
        r_best_val <= w_scan_val;
        r_best_idx <= r_scan;
      end
      if (w_scan_last) r_phase_o <= w_best_idx_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_sym   <= '0;
      r_q_sym   <= '0;
      r_sym_val <= 1'b0;
    end else begin
      r_sym_val <= w_hit;
      if (w_hit) begin
        r_i_sym <= i_in;
        r_q_sym <= q_in;
      end
    end
  end

endmodule

// File: tb/tb_sym_phase_decim.sv
// Directed bench for sym_phase_decim: two instances (4- and 64-symbol windows)
// share one stimulus stream; the 4-symbol instance is checked cycle by cycle.
module tb_sym_phase_decim;

  localparam int OSF = 20;
  localparam int WI  = 18;
  localparam int ACQ = 4;

  logic                 clk;
  logic                 rst;
  logic signed [WI-1:0] i_in;
  logic signed [WI-1:0] q_in;
  logic                 iq_val_i;
  logic                 reacq_i;

  logic signed [WI-1:0] o4_i, o4_q, o64_i, o64_q;
  logic                 o4_sv, o4_lk, o64_sv, o64_lk;
  logic [4:0]           o4_ph, o64_ph;

  int vectors    = 0;
  int miscompares = 0;
  int ph = 0;
  bit alt_tog = 1'b1;

  sym_phase_decim #(.OSF(OSF), .WI(WI), .ACQ_SYMS(ACQ)) dut4 (
    .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .iq_val_i(iq_val_i),
    .reacq_i(reacq_i), .i_sym(o4_i), .q_sym(o4_q), .sym_val_o(o4_sv),
    .phase_o(o4_ph), .lock_o(o4_lk)
  );

  sym_phase_decim #(.OSF(OSF), .WI(WI), .ACQ_SYMS(64)) dut64 (
    .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .iq_val_i(iq_val_i),
    .reacq_i(reacq_i), .i_sym(o64_i), .q_sym(o64_q), .sym_val_o(o64_sv),
    .phase_o(o64_ph), .lock_o(o64_lk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n cycles; impulses (ai, aq) on samples at phases p1/p2, zero elsewhere.
  // With chk set, sym_val_o is compared every cycle (expected only after a
  // valid sample at phase sv_ph) and the captured I/Q on each strobe.
  task automatic feed(input int n, input int p1, input int p2, input int ai,
                      input int aq, input bit alt, input int sv_ph, input bit chk_on);
    for (int k = 0; k < n; k++) begin
      bit v;
      bit hit;
      bit exp_sv;
      int p_cur;
      v = alt ? alt_tog : 1'b1;
      if (alt) alt_tog = ~alt_tog;
      hit = v && (ph == p1 || ph == p2);
      iq_val_i = v;
      reacq_i  = 1'b0;
      i_in = hit ? 18'(ai) : '0;
      q_in = hit ? 18'(aq) : '0;
      p_cur = ph;
      tick();
      if (v) ph = (ph + 1) % OSF;
      if (chk_on) begin
        exp_sv = v && (p_cur == sv_ph);
        chk("sym_val", 32'(o4_sv), 32'(exp_sv));
        if (exp_sv) begin
          chk("i_sym", 32'(o4_i), ai);
          chk("q_sym", 32'(o4_q), aq);
        end
      end
    end
  endtask

  task automatic acquire(input int p1, input int p2, input int ai, input int aq,
                         input bit alt, input int exp_ph);
    alt_tog = 1'b1;
    feed(alt ? 2 * ACQ * OSF - 1 : ACQ * OSF, p1, p2, ai, aq, alt, -1, 1'b1);
    feed(OSF - 1, p1, p2, ai, aq, alt, -1, 1'b1);
    chk("lock_in_select", 32'(o4_lk), 0);
    feed(1, p1, p2, ai, aq, alt, -1, 1'b1);
    chk("lock_after_select", 32'(o4_lk), 1);
    chk("phase_o", 32'(o4_ph), exp_ph);
  endtask

  // Reacq pulse coinciding with a valid sample that must be discarded.
  task automatic do_reacq(input int ai);
    iq_val_i = 1'b1;
    reacq_i  = 1'b1;
    i_in     = 18'(ai);
    q_in     = '0;
    tick();
    reacq_i = 1'b0;
    ph = 0;
    chk("reacq_lock", 32'(o4_lk), 0);
    chk("reacq_sym_val", 32'(o4_sv), 0);
  endtask

  initial begin
    rst = 1'b0; i_in = '0; q_in = '0; iq_val_i = 1'b0; reacq_i = 1'b0;
    repeat (2) tick();
    chk("rst_lock", 32'(o4_lk), 0);
    chk("rst_phase", 32'(o4_ph), 0);
    chk("rst_sym_val", 32'(o4_sv), 0);
    chk("rst_i_sym", 32'(o4_i), 0);
    chk("rst_q_sym", 32'(o4_q), 0);
    rst = 1'b1;
    ph = 0;

    // Impulse at phase 7, continuous valid.
    acquire(7, -1, 1000, 0, 1'b0, 7);
    feed(2 * OSF, 7, -1, 1000, 0, 1'b0, 7, 1'b1);
    chk("i_sym_hold", 32'(o4_i), 1000);

    // Reacq while the phase-7 sample is presented; relock at phase 15.
    feed(7, 7, -1, 1000, 0, 1'b0, 7, 1'b1);
    do_reacq(1000);
    chk("i_sym_hold_reacq", 32'(o4_i), 1000);
    acquire(15, -1, 1000, 0, 1'b0, 15);
    feed(OSF, 15, -1, 1000, 0, 1'b0, 15, 1'b1);

    // Equal pulses at phases 3 and 12: lowest index wins.
    do_reacq(0);
    acquire(3, 12, 500, 0, 1'b0, 3);
    feed(OSF, 3, 12, 500, 0, 1'b0, 3, 1'b1);

    // Asynchronous reset mid-SELECT, then full re-acquisition.
    do_reacq(0);
    feed(ACQ * OSF + 5, 7, -1, 1000, 0, 1'b0, -1, 1'b1);
    iq_val_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_lock", 32'(o4_lk), 0);
    chk("async_rst_phase", 32'(o4_ph), 0);
    chk("async_rst_i_sym", 32'(o4_i), 0);
    chk("async_rst_sym_val", 32'(o4_sv), 0);
    #1 rst = 1'b1;
    ph = 0;
    acquire(7, -1, 1000, 0, 1'b0, 7);
    feed(OSF, 7, -1, 1000, 0, 1'b0, 7, 1'b1);

    // Alternating valid, impulse at phase 9: strobes every 40 clocks.
    do_reacq(0);
    acquire(9, -1, 1000, 0, 1'b1, 9);
    feed(4 * OSF, 9, -1, 1000, 0, 1'b1, 9, 1'b1);

    // Most negative I and Q at phase 0 over a 64-symbol window.
    do_reacq(0);
    feed(64 * OSF + OSF, 0, -1, -131072, -131072, 1'b0, -1, 1'b0);
    chk("w64_lock", 32'(o64_lk), 1);
    chk("w64_phase", 32'(o64_ph), 0);
    chk("w64_bin0", 32'(dut64.r_bin[0]), 16777216);
    feed(1, 0, -1, -131072, -131072, 1'b0, -1, 1'b0);
    chk("w64_sym_val", 32'(o64_sv), 1);
    chk("w64_i_sym", 32'(o64_i), -131072);
    chk("w64_q_sym", 32'(o64_q), -131072);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sym_phase_decim.md
Name: sym_phase_decim

Overview:
- Symbol-timing decimator directly downstream of the √RC matched filter.
- Consumes the 200 MHz filtered I/Q stream (OSF=20 samples/symbol) and estimates the best sampling phase. It does this by accumulating |I|+|Q| per phase bin over a fixed acquisition window.
- After acquisition it emits one I/Q sample per symbol at that phase to the MSK demod/slicer.
- Re-acquisition is commanded externally.

Parameters:
- OSF, 20, samples per symbol; phase bins 0..OSF-1.
- WI, 18, input sample width (signed), matches matched-filter output width.
- ACQ_SYMS, 64, symbols accumulated per acquisition; power of 2, ≥2.
- ACC_W, WI+1+$clog2(ACQ_SYMS), per-bin accumulator width (unsigned), derived.

Ports:
- clk  in  1  sample clock (200 MHz).
- rst  in  1  reset; asynchronous assert, active-low.
- i_in  in  WI  matched-filter I, signed.
- q_in  in  WI  matched-filter Q, signed.
- iq_val_i  in  1  input sample valid.
- reacq_i  in  1  single-cycle pulse: restart acquisition.
- i_sym  out  WI  decimated I at the selected phase.
- q_sym  out  WI  decimated Q at the selected phase.
- sym_val_o  out  1  one-cycle strobe per output symbol.
- phase_o  out  $clog2(OSF)  selected phase; valid while lock_o=1.
- lock_o  out  1  high in TRACK.

Behaviour:
- Reset (rst=0, async):
  - i_sym, q_sym, sym_val_o, phase_o, lock_o = 0.
  - State ACQ; phase counter, symbol counter, scan index and all bins = 0.
- Phase counter:
  - Increments on each iq_val_i=1 and wraps OSF-1→0.
  - Runs in all states.
  - Cycles with iq_val_i=0 leave everything unchanged except the SELECT scan.
- Metric: mag = |I|+|Q|, computed as unsigned WI-bit magnitudes (−2^(WI-1) maps to exactly 2^(WI-1), no saturation), summed into WI+1 bits. Bins never overflow at ACC_W.
- State ACQ:
  - Each valid sample adds mag to bin[phase].
  - Symbol counter increments when a valid sample is taken at phase OSF-1.
  - When the ACQ_SYMS-th symbol completes, go to SELECT on the next cycle.
  - sym_val_o=0 and lock_o=0 throughout.
- State SELECT:
  - Scans one bin per clock, index 0..OSF-1, regardless of iq_val_i; takes exactly OSF cycles.
  - Keeps the running maximum; the update uses strict > so the lowest index wins ties.
  - Input samples in this state are counted by the phase counter but not accumulated or output.
  - After index OSF-1, register best→phase_o, set lock_o=1 and enter TRACK.
- State TRACK:
  - On a valid sample with phase counter == phase_o: register i_in/q_in into i_sym/q_sym and pulse sym_val_o the following cycle (1-clock latency).
  - Otherwise sym_val_o=0.
  - i_sym/q_sym hold their value between strobes.
- reacq_i=1 in any state:
  - Next cycle: state ACQ, lock_o=0, sym_val_o=0.
  - All bins, symbol counter and phase counter cleared to 0.
  - A valid sample in the same cycle as reacq_i is discarded (reacq wins).
  - i_sym/q_sym hold their last value.
- Bins are cleared only on reset or reacq. They are not cleared on entering TRACK, since they are unused until the next reacq.
- No backpressure: the downstream stage must accept every sym_val_o strobe.
- Sustained rate: at most one output per OSF valid inputs.

Test Plan:
- ACQ_SYMS=4; I=1000, Q=0 at phase 7, zeros elsewhere, iq_val_i=1 continuous.
  → After 80 valids plus 20 SELECT cycles: lock_o=1, phase_o=7.
  → Then sym_val_o every 20 cycles, i_sym=1000, q_sym=0, one cycle after the phase-7 input.
- Equal pulses (I=500) at phases 3 and 12.
  → phase_o=3 (tie to lowest index).
- I=Q=−131072 at phase 0, others 0, ACQ_SYMS=64.
  → bin[0]=64·262144=16777216 exactly, no wrap; phase_o=0; i_sym=q_sym=−131072.
- Impulse at phase 9, iq_val_i alternating 1/0.
  → Same lock result; phase_o=9; strobes every 40 clocks.
- Locked at phase 7; pulse reacq_i; impulses move to phase 15.
  → lock_o=0 the next cycle, no sym_val_o during ACQ/SELECT.
  → Relock with phase_o=15 (phase relative to the reacq point).
- Assert rst low mid-SELECT.
  → All outputs 0 asynchronously; after release, full re-acquisition reproduces the original phase_o.
